// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared encodings for the multi-cycle controller: opcodes,
//               state codes, datapath select encodings, fault codes and the
//               packed control-word type driven by mc_control_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // State codes
    localparam logic [3:0] ST_FETCH     = 4'd0;
    localparam logic [3:0] ST_DECODE    = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
    localparam logic [3:0] ST_MEM_READ  = 4'd3;
    localparam logic [3:0] ST_MEM_WB    = 4'd4;
    localparam logic [3:0] ST_MEM_WRITE = 4'd5;
    localparam logic [3:0] ST_EXECUTE   = 4'd6;
    localparam logic [3:0] ST_ALU_WB    = 4'd7;
    localparam logic [3:0] ST_BRANCH    = 4'd8;
    localparam logic [3:0] ST_JUMP      = 4'd9;
    localparam logic [3:0] ST_ADDI_EXEC = 4'd10;
    localparam logic [3:0] ST_ADDI_WB   = 4'd11;
    localparam logic [3:0] ST_RESET     = 4'd14;
    localparam logic [3:0] ST_FAULT     = 4'd15;

    // ALU operation
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Fault codes
    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // States that own the memory port and therefore run the wait watchdog
    function automatic logic is_mem_state(input logic [3:0] st);
        return (st == ST_FETCH) || (st == ST_MEM_READ) || (st == ST_MEM_WRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mc_mem_wait_timer
// Description : Counts consecutive not-ready cycles of a memory request and
//               flags a timeout on the last allowed waiting cycle.
// Ports       : clk, nrst (async active-low), en (memory state active),
//               clr (state is changing), ready (mem_ready), timeout (out)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    input  logic clr,
    input  logic ready,
    output logic timeout
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Ready on the final counted cycle beats the timeout.
    assign timeout = en && !ready && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multi-cycle main controller. Sequences fetch/decode/execute/
//               memory/writeback over a shared memory port, ALU, register
//               file, PC and IR, with a memory-ready watchdog and a sticky
//               fault. Build option: IMM_ALU_EN adds addi (ADDI_EXEC/ADDI_WB).
// Ports       : clk, nrst (async active-low), opcode[5:0], zero, mem_ready;
//               datapath controls pc_write .. pc_source; state_o[3:0];
//               fault, fault_code[1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state_o,
    output logic       fault,
    output logic [1:0] fault_code
);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [1:0] w_fault_code_next;
    logic       r_fault;
    logic [1:0] r_fault_code;
    logic       w_timeout;
    ctrl_t      w_ctrl;

    // Branch resolution happens in the datapath; the flag is only observed.
    logic w_unused_zero;
    assign w_unused_zero = zero;

    mc_mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .nrst    (nrst),
        .en      (is_mem_state(r_state)),
        .clr     (w_next_state != r_state),
        .ready   (mem_ready),
        .timeout (w_timeout)
    );

    // Next-state logic; w_fault_code_next only matters when entering FAULT.
    always_comb begin
        w_next_state      = r_state;
        w_fault_code_next = FAULT_ILLEGAL;
        case (r_state)
            ST_RESET: w_next_state = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    w_next_state = ST_DECODE;
                end else if (w_timeout) begin
                    w_next_state      = ST_FAULT;
                    w_fault_code_next = FAULT_TIMEOUT;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_next_state = ST_EXECUTE;
                    OP_LW, OP_SW: w_next_state = ST_MEM_ADDR;
                    OP_BEQ:       w_next_state = ST_BRANCH;
                    OP_J:         w_next_state = ST_JUMP;
`ifdef IMM_ALU_EN
                    OP_ADDI:      w_next_state = ST_ADDI_EXEC;
`endif
                    default:      w_next_state = ST_FAULT;
                endcase
            end
            ST_MEM_ADDR: w_next_state = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ, ST_MEM_WRITE: begin
                if (mem_ready) begin
                    w_next_state = (r_state == ST_MEM_READ) ? ST_MEM_WB : ST_FETCH;
                end else if (w_timeout) begin
                    w_next_state      = ST_FAULT;
                    w_fault_code_next = FAULT_TIMEOUT;
                end
            end
            ST_EXECUTE: w_next_state = ST_ALU_WB;
            ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JUMP: w_next_state = ST_FETCH;
`ifdef IMM_ALU_EN
            ST_ADDI_EXEC: w_next_state = ST_ADDI_WB;
            ST_ADDI_WB:   w_next_state = ST_FETCH;
`endif
            ST_FAULT: w_next_state = ST_FAULT;
            // Unused / disabled codes collapse into an illegal-state fault.
            default:  w_next_state = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_RESET;
            r_fault      <= 1'b0;
            r_fault_code <= FAULT_NONE;
        end else begin
            r_state <= w_next_state;
            if ((w_next_state == ST_FAULT) && (r_state != ST_FAULT)) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_fault_code_next;
            end
        end
    end

    // Control decode from the state register.
    always_comb begin
        w_ctrl = CTRL_IDLE;
        case (r_state)
            ST_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = SRC_B_FOUR;
                w_ctrl.alu_op    = ALU_OP_ADD;
                w_ctrl.pc_source = PC_SRC_ALU;
                w_ctrl.ir_write  = mem_ready;
                w_ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                w_ctrl.alu_src_b = SRC_B_IMM_SH2;
                w_ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_ADDR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRC_B_IMM;
                w_ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_READ: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
            end
            ST_EXECUTE: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRC_B_REG;
                w_ctrl.alu_op    = ALU_OP_FUNCT;
            end
            ST_ALU_WB: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = SRC_B_REG;
                w_ctrl.alu_op        = ALU_OP_SUB;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PC_SRC_ALUOUT;
            end
            ST_JUMP: begin
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.pc_source = PC_SRC_JUMP;
            end
`ifdef IMM_ALU_EN
            ST_ADDI_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRC_B_IMM;
                w_ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_ADDI_WB: begin
                w_ctrl.reg_write = 1'b1;
            end
`endif
            default: w_ctrl = CTRL_IDLE;
        endcase
    end

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign iord          = w_ctrl.iord;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign ir_write      = w_ctrl.ir_write;
    assign reg_dst       = w_ctrl.reg_dst;
    assign reg_write     = w_ctrl.reg_write;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign pc_source     = w_ctrl.pc_source;
    assign state_o       = r_state;
    assign fault         = r_fault;
    assign fault_code    = r_fault_code;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Scoreboard bench for mc_control_fsm. Stimulus pushes the
//               hand-derived per-cycle expectation; a monitor pops and
//               compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg;
    logic       ir_write, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source, fault_code;
    logic [3:0] state_o;
    logic       fault;

    always #5 clk = ~clk;

    mc_control_fsm #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .nrst(nrst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state_o(state_o), .fault(fault), .fault_code(fault_code)
    );

    typedef struct {
        int         step;
        logic [3:0] st;
        logic [15:0] c;
        logic       f;
        logic [1:0] fc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_step   = 0;

    // Control word order: pcw pcwc iord mr mw m2r irw rd rw asa | b op ps
    function automatic logic [15:0] mk(input logic pcw, pcwc, io, mr, mw, m2r, irw, rd, rw, asa,
                                       input logic [1:0] b, op, ps);
        return {pcw, pcwc, io, mr, mw, m2r, irw, rd, rw, asa, b, op, ps};
    endfunction

    logic [15:0] e_zero, e_fetch_rdy, e_fetch_wait, e_decode, e_mem_addr, e_mem_rd;
    logic [15:0] e_mem_wb, e_mem_wr, e_exec, e_alu_wb, e_branch, e_jump, e_addi_ex, e_addi_wb;

    wire [15:0] act = {pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg,
                       ir_write, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    task automatic push(input logic [3:0] st, input logic [15:0] c, input logic f, input logic [1:0] fc);
        exp_t e;
        e.step = n_step; e.st = st; e.c = c; e.f = f; e.fc = fc;
        sb.push_back(e);
        n_step++;
    endtask

    // One clock: after the edge, drive inputs and record the expectation
    task automatic cyc(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                       input logic [15:0] c, input logic f, input logic [1:0] fc);
        @(posedge clk); #1;
        opcode = op; mem_ready = rdy;
        push(st, c, f, fc);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        nrst = 1'b0; opcode = 6'd0; mem_ready = 1'b0;
        #1 push(4'd14, e_zero, 1'b0, 2'b00);
        @(posedge clk); #1;
        nrst = 1'b1;
        push(4'd14, e_zero, 1'b0, 2'b00);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (state_o === e.st && act === e.c && fault === e.f && fault_code === e.fc)
                    n_pass++;
                else
                    $display("FAIL step %0d: got state=%0d ctrl=%h fault=%b code=%b, want state=%0d ctrl=%h fault=%b code=%b",
                             e.step, state_o, act, fault, fault_code, e.st, e.c, e.f, e.fc);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        e_zero       = '0;
        e_fetch_rdy  = mk(1,0,0,1,0,0,1,0,0,0, 2'b01, 2'b00, 2'b00);
        e_fetch_wait = mk(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00);
        e_decode     = mk(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00);
        e_mem_addr   = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
        e_mem_rd     = mk(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
        e_mem_wb     = mk(0,0,0,0,0,1,0,0,1,0, 2'b00, 2'b00, 2'b00);
        e_mem_wr     = mk(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
        e_exec       = mk(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00);
        e_alu_wb     = mk(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00);
        e_branch     = mk(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01);
        e_jump       = mk(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10);
        e_addi_ex    = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
        e_addi_wb    = mk(0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00);

        do_reset();

        // R-type: 0,1,6,7
        cyc(6'b000000, 1'b1, 4'd0, e_fetch_rdy, 1'b0, 2'b00);
        cyc(6'b000000, 1'b0, 4'd1, e_decode,    1'b0, 2'b00);
        cyc(6'b000000, 1'b0, 4'd6, e_exec,      1'b0, 2'b00);
        cyc(6'b000000, 1'b0, 4'd7, e_alu_wb,    1'b0, 2'b00);

        // lw with three wait cycles in MEM_READ
        cyc(6'b100011, 1'b1, 4'd0, e_fetch_rdy, 1'b0, 2'b00);
        cyc(6'b100011, 1'b0, 4'd1, e_decode,    1'b0, 2'b00);
        cyc(6'b100011, 1'b0, 4'd2, e_mem_addr,  1'b0, 2'b00);
        for (int i = 0; i < 3; i++)
            cyc(6'b100011, 1'b0, 4'd3, e_mem_rd, 1'b0, 2'b00);
        cyc(6'b100011, 1'b1, 4'd3, e_mem_rd,    1'b0, 2'b00);
        cyc(6'b100011, 1'b0, 4'd4, e_mem_wb,    1'b0, 2'b00);

        // beq then j; FETCH of j waits two cycles (ir_write/pc_write gated)
        cyc(6'b000100, 1'b1, 4'd0, e_fetch_rdy, 1'b0, 2'b00);
        cyc(6'b000100, 1'b0, 4'd1, e_decode,    1'b0, 2'b00);
        cyc(6'b000100, 1'b0, 4'd8, e_branch,    1'b0, 2'b00);
        cyc(6'b000010, 1'b0, 4'd0, e_fetch_wait,1'b0, 2'b00);
        cyc(6'b000010, 1'b0, 4'd0, e_fetch_wait,1'b0, 2'b00);
        cyc(6'b000010, 1'b1, 4'd0, e_fetch_rdy, 1'b0, 2'b00);
        cyc(6'b000010, 1'b0, 4'd1, e_decode,    1'b0, 2'b00);
        cyc(6'b000010, 1'b0, 4'd9, e_jump,      1'b0, 2'b00);

        // addi
        cyc(6'b001000, 1'b1, 4'd0, e_fetch_rdy, 1'b0, 2'b00);
        cyc(6'b001000, 1'b0, 4'd1, e_decode,    1'b0, 2'b00);
`ifdef IMM_ALU_EN
        cyc(6'b001000, 1'b0, 4'd10, e_addi_ex,  1'b0, 2'b00);
        cyc(6'b001000, 1'b0, 4'd11, e_addi_wb,  1'b0, 2'b00);
        cyc(6'b001000, 1'b0, 4'd0,  e_fetch_wait, 1'b0, 2'b00);
`else
        cyc(6'b001000, 1'b0, 4'd15, e_zero,     1'b1, 2'b01);
`endif
        do_reset();

        // sw with mem_ready never asserted: 16 cycles in state 5, then timeout fault
        cyc(6'b101011, 1'b1, 4'd0, e_fetch_rdy, 1'b0, 2'b00);
        cyc(6'b101011, 1'b0, 4'd1, e_decode,    1'b0, 2'b00);
        cyc(6'b101011, 1'b0, 4'd2, e_mem_addr,  1'b0, 2'b00);
        for (int i = 0; i < 16; i++)
            cyc(6'b101011, 1'b0, 4'd5, e_mem_wr, 1'b0, 2'b00);
        cyc(6'b101011, 1'b1, 4'd15, e_zero,     1'b1, 2'b10);
        cyc(6'b000000, 1'b1, 4'd15, e_zero,     1'b1, 2'b10);
        do_reset();

        // lw with ready arriving on the 16th waiting cycle: no fault
        cyc(6'b100011, 1'b1, 4'd0, e_fetch_rdy, 1'b0, 2'b00);
        cyc(6'b100011, 1'b0, 4'd1, e_decode,    1'b0, 2'b00);
        cyc(6'b100011, 1'b0, 4'd2, e_mem_addr,  1'b0, 2'b00);
        for (int i = 0; i < 15; i++)
            cyc(6'b100011, 1'b0, 4'd3, e_mem_rd, 1'b0, 2'b00);
        cyc(6'b100011, 1'b1, 4'd3, e_mem_rd,    1'b0, 2'b00);
        cyc(6'b100011, 1'b0, 4'd4, e_mem_wb,    1'b0, 2'b00);

        // Illegal opcode
        cyc(6'b111111, 1'b1, 4'd0, e_fetch_rdy, 1'b0, 2'b00);
        cyc(6'b111111, 1'b0, 4'd1, e_decode,    1'b0, 2'b00);
        cyc(6'b111111, 1'b0, 4'd15, e_zero,     1'b1, 2'b01);
        cyc(6'b000000, 1'b1, 4'd15, e_zero,     1'b1, 2'b01);
        do_reset();

        // Reset abandons an outstanding fetch request
        cyc(6'b000000, 1'b0, 4'd0, e_fetch_wait, 1'b0, 2'b00);
        do_reset();
        cyc(6'b000000, 1'b0, 4'd0, e_fetch_wait, 1'b0, 2'b00);

        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle main controller that sequences the shared datapath: one memory port, one ALU, register file, PC and IR.
- Decodes the 6-bit opcode held in IR and steps through fetch, decode, execute, memory and writeback states.
- Drives every datapath mux select and write enable for each step.
- Handles a ready handshake on the shared memory, with a timeout watchdog and a sticky fault.

Parameters:
- TIMEOUT_CYCLES, 16, maximum consecutive cycles a memory state waits for mem_ready before faulting (range 2..31).
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- nrst  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26]; valid from DECODE onward
- zero  input  1  ALU zero flag (informational; branch gating is done in the datapath)
- mem_ready  input  1  memory completes the current request this cycle
- pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg, ir_write, reg_dst, reg_write, alu_src_a  output  1 each  datapath controls
- alu_src_b  output  2  ALU B select: 00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2
- alu_op  output  2  00 add, 01 sub, 10 funct-decoded
- pc_source  output  2  00 ALU, 01 ALUOut, 10 jump target
- state_o  output  4  current state code
- fault  output  1  sticky fault flag
- fault_code  output  2  01 illegal opcode, 10 memory timeout, 00 none

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low on nrst.
  - Reset forces state = RESET(14), wait counter = 0, fault = 0, fault_code = 00.
  - In RESET all control outputs are 0. The next edge after reset deasserts enters FETCH.
- Outputs are decoded combinationally from the state register. Only ir_write and pc_write in FETCH are qualified by mem_ready.
- States (code) and outputs; any output not listed is 0:
  - FETCH(0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. Leave for DECODE when mem_ready=1, else stay.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
    - 000000 -> EXECUTE
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - anything else -> FAULT with fault_code=01
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ(3): mem_read=1, iord=1. Goes to MEM_WB on mem_ready.
  - MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
  - MEM_WRITE(5): mem_write=1, iord=1. Goes to FETCH on mem_ready.
  - EXECUTE(6): alu_src_a=1, alu_src_b=00, alu_op=10. Next ALU_WB.
  - ALU_WB(7): reg_dst=1, reg_write=1. Next FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next FETCH.
  - JUMP(9): pc_write=1, pc_source=10. Next FETCH.
  - FAULT(15): all controls 0, fault=1. Absorbing until reset.
- Memory handshake and timeout (FETCH, MEM_READ, MEM_WRITE):
  - The request (mem_read or mem_write) holds steady until mem_ready is sampled high.
  - The wait counter increments each cycle mem_ready=0 and clears on state change.
  - If the counter equals TIMEOUT_CYCLES-1 and mem_ready=0, go to FAULT with fault_code=10. Total wait is exactly TIMEOUT_CYCLES cycles.
  - mem_ready=1 on the final counted cycle wins over the timeout.
- fault and fault_code are set on entry to FAULT and clear only on reset. Reset mid-operation abandons any request immediately.
- Unused codes (12, 13) behave as FAULT with fault_code=01.

Optional Feature:
- IMM_ALU_EN defined:
  - In DECODE, opcode 001000 (addi) goes to ADDI_EXEC(10): alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_EXEC goes to ADDI_WB(11): reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- IMM_ALU_EN undefined: 001000 is illegal (FAULT, fault_code=01), and codes 10/11 are unreachable and treated as FAULT.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - state code constants
  - alu_op, alu_src_b and pc_source encodings
  - fault_code values
- One natural sub-module, mc_mem_wait_timer: the wait counter plus timeout compare, taking enable/clear/ready and producing timeout.

Test Plan:
- Reset, then R-type (opcode 000000) with mem_ready=1 -> state sequence 14,0,1,6,7,0; ir_write=pc_write=1 in the FETCH cycle; reg_write=1, reg_dst=1 in state 7.
- lw (100011) with mem_ready held low for 3 cycles in MEM_READ -> mem_read=1, iord=1 for 4 cycles; MEM_WB follows with mem_to_reg=1; no fault.
- sw (101011) with mem_ready never asserted, TIMEOUT_CYCLES=16 -> exactly 16 cycles in state 5, then state 15, fault=1, fault_code=10.
- Opcode 111111 in DECODE -> FAULT next cycle with fault_code=01 and all controls 0; nrst pulse -> RESET with fault=0.
- beq (000100) then j (000010) -> BRANCH shows pc_write_cond=1, pc_source=01, alu_op=01; JUMP shows pc_write=1, pc_source=10.
- addi (001000): with IMM_ALU_EN -> states 1,10,11,0; without it -> FAULT with fault_code=01.
